// File: rtl/uart_mimo_link.sv
// UART-framed loader for MIMO H/Y sample stores: streams both to the decoder once
// loaded, then returns the synchronised decoder result over the same UART link.
module uart_mimo_link #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned N_H         = 16,
    parameter int unsigned N_Y         = 8,
    parameter int unsigned RES_W       = 12,
    parameter int unsigned TIMEOUT_CYC = 5000000
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [7:0]        rx_byte,
    input  logic              rx_valid,
    output logic [7:0]        tx_byte,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic [DATA_W-1:0] h_re_out,
    output logic [DATA_W-1:0] h_im_out,
    output logic              h_valid,
    output logic [DATA_W-1:0] y_re_out,
    output logic [DATA_W-1:0] y_im_out,
    output logic              y_valid,
    output logic              start,
    input  logic              res_valid,
    input  logic [RES_W-1:0]  res_data,
    output logic              frame_err,
    output logic [3:0]        state_dbg
);

    localparam int unsigned EW    = 2 * DATA_W;
    localparam int unsigned BPE   = EW / 8;
    localparam int unsigned BCW   = (BPE > 1) ? $clog2(BPE) : 1;
    localparam int unsigned HIW   = (N_H > 1) ? $clog2(N_H) : 1;
    localparam int unsigned NRB   = (RES_W + 7) / 8;
    localparam int unsigned RBITS = NRB * 8;
    localparam int unsigned RBW   = $clog2(NRB + 1);
    localparam int unsigned TW    = $clog2(TIMEOUT_CYC + 1);

    localparam logic [BCW-1:0] LAST_BYTE = BCW'(BPE - 1);
    localparam logic [HIW-1:0] LAST_H    = HIW'(N_H - 1);
    localparam logic [HIW-1:0] LAST_Y    = HIW'(N_Y - 1);
    localparam logic [HIW:0]   NY_CNT    = (HIW + 1)'(N_Y);
    localparam logic [TW-1:0]  TO_LAST   = TW'(TIMEOUT_CYC - 1);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_RX_H     = 4'd1;
    localparam logic [3:0] S_RX_Y     = 4'd2;
    localparam logic [3:0] S_RX_CHK   = 4'd3;
    localparam logic [3:0] S_ACK      = 4'd4;
    localparam logic [3:0] S_STREAM   = 4'd5;
    localparam logic [3:0] S_WAIT_RES = 4'd6;
    localparam logic [3:0] S_TX_RES   = 4'd7;
    localparam logic [3:0] S_TX_WAIT  = 4'd8;

    logic [3:0]       r_state;
    logic             r_is_y;
    logic [BCW-1:0]   r_byte_cnt;
    logic [HIW-1:0]   r_elem;
    logic [7:0]       r_chk;
    logic [TW-1:0]    r_to_cnt;
    logic [EW-9:0]    r_asm;
    logic             r_h_loaded;
    logic             r_y_loaded;
    logic [7:0]       r_ack;
    logic [HIW-1:0]   r_str_idx;
    logic [2:0]       r_rv_sync;
    logic [RES_W-1:0] r_rd_s1;
    logic [RES_W-1:0] r_rd_s2;
    logic [RBITS-1:0] r_res;
    logic [RBW-1:0]   r_res_idx;
    logic             r_in_res;

    // Y store is sized like H so both share the stream index without width games.
    logic [EW-1:0]    r_h_mem [N_H];
    logic [EW-1:0]    r_y_mem [N_H];

    logic [EW-1:0]    w_elem;
    logic             w_rx_data;
    logic             w_elem_we;
    logic [HIW-1:0]   w_last_elem;
    logic [HIW-1:0]   w_str_nxt;
    logic             w_y_in;
    logic [7:0]       w_res_byte;

    assign state_dbg   = r_state;
    assign w_elem      = {rx_byte, r_asm};
    assign w_rx_data   = rx_valid && (r_state == S_RX_H || r_state == S_RX_Y);
    assign w_elem_we   = w_rx_data && (r_byte_cnt == LAST_BYTE);
    assign w_last_elem = r_is_y ? LAST_Y : LAST_H;
    assign w_str_nxt   = r_str_idx + 1'b1;
    assign w_y_in      = {1'b0, w_str_nxt} < NY_CNT;

    always_comb begin
        w_res_byte = 8'h00;
        for (int b = 0; b < int'(NRB); b++) begin
            if (r_res_idx == RBW'(b + 1)) w_res_byte = r_res[b*8 +: 8];
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (w_elem_we) begin
            if (r_is_y) r_y_mem[r_elem] <= w_elem;
            else        r_h_mem[r_elem] <= w_elem;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_is_y     <= 1'b0;
            r_byte_cnt <= '0;
            r_elem     <= '0;
            r_chk      <= 8'h00;
            r_to_cnt   <= '0;
            r_asm      <= '0;
            r_h_loaded <= 1'b0;
            r_y_loaded <= 1'b0;
            r_ack      <= 8'h00;
            r_str_idx  <= '0;
            r_rv_sync  <= 3'b000;
            r_rd_s1    <= '0;
            r_rd_s2    <= '0;
            r_res      <= '0;
            r_res_idx  <= '0;
            r_in_res   <= 1'b0;
            tx_byte    <= 8'h00;
            tx_start   <= 1'b0;
            h_re_out   <= '0;
            h_im_out   <= '0;
            h_valid    <= 1'b0;
            y_re_out   <= '0;
            y_im_out   <= '0;
            y_valid    <= 1'b0;
            start      <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            tx_start  <= 1'b0;
            r_rv_sync <= {r_rv_sync[1:0], res_valid};
            r_rd_s1   <= res_data;
            r_rd_s2   <= r_rd_s1;
            case (r_state)
                S_IDLE: begin
                    if (rx_valid && (rx_byte == 8'hAA || rx_byte == 8'hBB)) begin
                        r_state    <= (rx_byte == 8'hAA) ? S_RX_H : S_RX_Y;
                        r_is_y     <= (rx_byte == 8'hBB);
                        frame_err  <= 1'b0;
                        r_byte_cnt <= '0;
                        r_elem     <= '0;
                        r_chk      <= 8'h00;
                        r_to_cnt   <= '0;
                    end
                end
                S_RX_H, S_RX_Y, S_RX_CHK: begin
                    if (rx_valid) begin
                        r_to_cnt <= '0;
                        if (r_state == S_RX_CHK) begin
                            if (rx_byte == r_chk) begin
                                if (r_is_y) r_y_loaded <= 1'b1;
                                else        r_h_loaded <= 1'b1;
                                r_ack <= 8'h06;
                            end else begin
                                if (r_is_y) r_y_loaded <= 1'b0;
                                else        r_h_loaded <= 1'b0;
                                frame_err <= 1'b1;
                                r_ack     <= 8'h15;
                            end
                            r_state <= S_ACK;
                        end else begin
                            r_chk <= r_chk ^ rx_byte;
                            for (int b = 0; b < int'(BPE) - 1; b++) begin
                                if (r_byte_cnt == BCW'(b)) r_asm[b*8 +: 8] <= rx_byte;
                            end
                            if (r_byte_cnt == LAST_BYTE) begin
                                r_byte_cnt <= '0;
                                if (r_elem == w_last_elem) r_state <= S_RX_CHK;
                                else                       r_elem  <= r_elem + 1'b1;
                            end else begin
                                r_byte_cnt <= r_byte_cnt + 1'b1;
                            end
                        end
                    end else if (r_to_cnt == TO_LAST) begin
                        // Abandoned frame: drop it silently, no NAK is sent.
                        r_state   <= S_IDLE;
                        frame_err <= 1'b1;
                        if (r_is_y) r_y_loaded <= 1'b0;
                        else        r_h_loaded <= 1'b0;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                S_ACK: begin
                    if (!tx_busy) begin
                        tx_byte  <= r_ack;
                        tx_start <= 1'b1;
                        r_state  <= S_TX_WAIT;
                    end
                end
                S_TX_WAIT: begin
                    if (r_in_res) begin
                        if (r_res_idx == '0) begin
                            r_in_res <= 1'b0;
                            r_state  <= S_IDLE;
                        end else begin
                            r_state <= S_TX_RES;
                        end
                    end else if (r_h_loaded && r_y_loaded) begin
                        r_state   <= S_STREAM;
                        r_str_idx <= '0;
                        start     <= 1'b1;
                        h_valid   <= 1'b1;
                        h_re_out  <= r_h_mem[0][DATA_W-1:0];
                        h_im_out  <= r_h_mem[0][EW-1:DATA_W];
                        y_valid   <= 1'b1;
                        y_re_out  <= r_y_mem[0][DATA_W-1:0];
                        y_im_out  <= r_y_mem[0][EW-1:DATA_W];
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_STREAM: begin
                    start <= 1'b0;
                    if (r_str_idx == LAST_H) begin
                        h_valid    <= 1'b0;
                        y_valid    <= 1'b0;
                        h_re_out   <= '0;
                        h_im_out   <= '0;
                        y_re_out   <= '0;
                        y_im_out   <= '0;
                        r_h_loaded <= 1'b0;
                        r_y_loaded <= 1'b0;
                        r_state    <= S_WAIT_RES;
                    end else begin
                        r_str_idx <= w_str_nxt;
                        h_re_out  <= r_h_mem[w_str_nxt][DATA_W-1:0];
                        h_im_out  <= r_h_mem[w_str_nxt][EW-1:DATA_W];
                        y_valid   <= w_y_in;
                        y_re_out  <= w_y_in ? r_y_mem[w_str_nxt][DATA_W-1:0] : '0;
                        y_im_out  <= w_y_in ? r_y_mem[w_str_nxt][EW-1:DATA_W] : '0;
                    end
                end
                S_WAIT_RES: begin
                    if (r_rv_sync[1] && !r_rv_sync[2]) begin
                        r_res     <= RBITS'(r_rd_s2);
                        r_res_idx <= RBW'(NRB);
                        r_in_res  <= 1'b1;
                        r_state   <= S_TX_RES;
                    end
                end
                S_TX_RES: begin
                    if (!tx_busy) begin
                        tx_byte   <= w_res_byte;
                        tx_start  <= 1'b1;
                        r_res_idx <= r_res_idx - 1'b1;
                        r_state   <= S_TX_WAIT;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_mimo_link.sv
// Scoreboard bench for uart_mimo_link: directed frames push expected tx bytes and
// stream cycles; a negedge monitor pops and compares whatever the DUT presents.
module tb_uart_mimo_link;

    localparam int DW = 16;

    typedef struct packed {
        logic          st;
        logic [DW-1:0] hr;
        logic [DW-1:0] hi;
        logic          yv;
        logic [DW-1:0] yr;
        logic [DW-1:0] yi;
    } str_t;

    logic          CLOCK_50 = 1'b0;
    logic          reset;
    logic [7:0]    rx_byte;
    logic          rx_valid;
    logic [7:0]    tx_byte;
    logic          tx_start;
    logic          tx_busy;
    logic [DW-1:0] h_re_out, h_im_out, y_re_out, y_im_out;
    logic          h_valid, y_valid, start;
    logic          res_valid;
    logic [11:0]   res_data;
    logic          frame_err;
    logic [3:0]    state_dbg;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic [7:0] exp_tx[$];
    str_t       exp_str[$];
    logic       prev_tx_start = 1'b0;
    str_t       e_str;
    str_t       a_str;
    logic [7:0] e_tx;

    localparam logic [63:0] H_PL = 64'h0004_0003_0002_0001;
    localparam logic [63:0] Y_PL = 64'h0000_0000_0006_0005;

    uart_mimo_link #(
        .DATA_W(16), .N_H(2), .N_Y(1), .RES_W(12), .TIMEOUT_CYC(100)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .tx_byte  (tx_byte),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .h_re_out (h_re_out),
        .h_im_out (h_im_out),
        .h_valid  (h_valid),
        .y_re_out (y_re_out),
        .y_im_out (y_im_out),
        .y_valid  (y_valid),
        .start    (start),
        .res_valid(res_valid),
        .res_data (res_data),
        .frame_err(frame_err),
        .state_dbg(state_dbg)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Transmitter model: busy for a few clocks after each accepted start.
    always @(posedge CLOCK_50) begin
        if (tx_start && !reset) begin
            #1 tx_busy = 1'b1;
            repeat (3) @(posedge CLOCK_50);
            #1 tx_busy = 1'b0;
        end
    end

    always @(negedge CLOCK_50) begin
        if (!reset) begin
            if (tx_start) begin
                check("tx_while_busy", 128'(tx_busy), 128'(0));
                check("tx_start_one_cycle", 128'(prev_tx_start), 128'(0));
                if (exp_tx.size() == 0) begin
                    check("tx_unexpected", 128'(tx_byte), 128'h1ff);
                end else begin
                    e_tx = exp_tx.pop_front();
                    check("tx_byte", 128'(tx_byte), 128'(e_tx));
                end
            end
            prev_tx_start = tx_start;
            if (h_valid) begin
                if (exp_str.size() == 0) begin
                    check("stream_unexpected", 128'(h_valid), 128'(0));
                end else begin
                    e_str = exp_str.pop_front();
                    a_str = '{st: start, hr: h_re_out, hi: h_im_out, yv: y_valid,
                              yr: e_str.yv ? y_re_out : '0, yi: e_str.yv ? y_im_out : '0};
                    check("stream_cycle", 128'(a_str), 128'(e_str));
                end
            end else begin
                check("idle_qualifiers", 128'({start, y_valid}), 128'(0));
            end
        end else begin
            prev_tx_start = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge CLOCK_50);
        #1;
        rx_byte  = b;
        rx_valid = 1'b1;
        @(posedge CLOCK_50);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] hdr, input logic [63:0] pl, input int n,
                              input logic [7:0] chk, input bit with_hdr);
        if (with_hdr) send_byte(hdr);
        for (int i = 0; i < n; i++) send_byte(pl[i*8 +: 8]);
        send_byte(chk);
    endtask

    task automatic wait_drain(input string name, input int max_cyc);
        int c = 0;
        while ((exp_tx.size() != 0 || exp_str.size() != 0) && c < max_cyc) begin
            @(posedge CLOCK_50);
            c++;
        end
        #1;
        check(name, 128'(exp_tx.size() + exp_str.size()), 128'(0));
    endtask

    task automatic wait_idle(input string name, input int max_cyc);
        int c = 0;
        while (state_dbg != 4'd0 && c < max_cyc) begin
            @(posedge CLOCK_50);
            #1;
            c++;
        end
        check(name, 128'(state_dbg), 128'(0));
    endtask

    task automatic send_result(input logic [11:0] d);
        @(posedge CLOCK_50);
        #1;
        res_data  = d;
        res_valid = 1'b1;
        repeat (3) @(posedge CLOCK_50);
        #1;
        res_valid = 1'b0;
    endtask

    task automatic push_stream();
        exp_str.push_back('{st: 1'b1, hr: 16'd1, hi: 16'd2, yv: 1'b1, yr: 16'd5, yi: 16'd6});
        exp_str.push_back('{st: 1'b0, hr: 16'd3, hi: 16'd4, yv: 1'b0, yr: 16'd0, yi: 16'd0});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        reset     = 1'b1;
        rx_byte   = 8'h00;
        rx_valid  = 1'b0;
        tx_busy   = 1'b0;
        res_valid = 1'b0;
        res_data  = 12'h000;
        repeat (3) @(posedge CLOCK_50);
        #1;
        check("reset_state", 128'(state_dbg), 128'(0));
        check("reset_outputs", 128'({tx_start, tx_byte, start, h_valid, y_valid, frame_err}),
              128'(0));
        check("reset_data", 128'({h_re_out, h_im_out, y_re_out, y_im_out}), 128'(0));
        reset = 1'b0;

        // H frame alone: ACK, no stream
        exp_tx.push_back(8'h06);
        send_frame(8'hAA, H_PL, 8, 8'h04, 1'b1);
        wait_drain("h_ack", 40);
        wait_idle("h_idle", 20);
        check("h_frame_err", 128'(frame_err), 128'(0));

        // Y frame completes the pair: ACK then two stream cycles
        exp_tx.push_back(8'h06);
        push_stream();
        send_frame(8'hBB, Y_PL, 4, 8'h03, 1'b1);
        wait_drain("y_ack_stream", 40);

        // Result 0xABC goes out MSB byte first
        exp_tx.push_back(8'h0A);
        exp_tx.push_back(8'hBC);
        send_result(12'hABC);
        wait_drain("result_abc", 60);
        wait_idle("result_idle", 20);

        // Bad H checksum: NAK, frame_err; following Y must not stream
        exp_tx.push_back(8'h15);
        send_frame(8'hAA, H_PL, 8, 8'h05, 1'b1);
        wait_drain("h_nak", 40);
        wait_idle("nak_idle", 20);
        check("nak_frame_err", 128'(frame_err), 128'(1));
        exp_tx.push_back(8'h06);
        send_frame(8'hBB, Y_PL, 4, 8'h03, 1'b1);
        wait_drain("y_after_nak", 40);
        wait_idle("no_stream_idle", 20);
        check("header_clears_err", 128'(frame_err), 128'(0));
        repeat (10) @(posedge CLOCK_50);

        // Timeout: AA 01 00 then silence
        send_byte(8'hAA);
        send_byte(8'h01);
        send_byte(8'h00);
        repeat (98) @(posedge CLOCK_50);
        #1;
        check("timeout_not_early", 128'(state_dbg != 4'd0), 128'(1));
        repeat (3) @(posedge CLOCK_50);
        #1;
        check("timeout_idle", 128'(state_dbg), 128'(0));
        check("timeout_frame_err", 128'(frame_err), 128'(1));

        // Good H with Y still loaded streams; reset lands in stream cycle 1
        exp_tx.push_back(8'h06);
        push_stream();
        send_frame(8'hAA, H_PL, 8, 8'h04, 1'b1);
        c = 0;
        while (exp_str.size() != 0 && c < 60) begin
            @(negedge CLOCK_50);
            #1;
            c++;
        end
        check("pre_reset_stream", 128'(exp_str.size() + exp_tx.size()), 128'(0));
        reset = 1'b1;
        @(posedge CLOCK_50);
        #1;
        check("midstream_reset_state", 128'(state_dbg), 128'(0));
        check("midstream_reset_outs",
              128'({tx_start, tx_byte, start, h_valid, y_valid, frame_err}), 128'(0));
        check("midstream_reset_data", 128'({h_re_out, h_im_out, y_re_out, y_im_out}), 128'(0));

        // Header presented with reset release is taken on the first clock
        @(negedge CLOCK_50);
        reset    = 1'b0;
        rx_byte  = 8'hAA;
        rx_valid = 1'b1;
        @(posedge CLOCK_50);
        #1;
        rx_valid = 1'b0;
        exp_tx.push_back(8'h06);
        send_frame(8'hAA, H_PL, 8, 8'h04, 1'b0);
        wait_drain("post_reset_h_ack", 40);
        wait_idle("post_reset_h_idle", 20);
        exp_tx.push_back(8'h06);
        push_stream();
        send_frame(8'hBB, Y_PL, 4, 8'h03, 1'b1);
        wait_drain("post_reset_stream", 40);

        // Zero-padded top byte
        exp_tx.push_back(8'h00);
        exp_tx.push_back(8'hF3);
        send_result(12'h0F3);
        wait_drain("result_0f3", 60);
        wait_idle("final_idle", 20);

        repeat (5) @(posedge CLOCK_50);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_mimo_link.md
UART_MIMO_LINK -- requirements
Module: uart_mimo_link

Interface
REQ-001 SHALL have parameter DATA_W, default 32, sample width per re/im component in bits (multiple of 8).
REQ-002 SHALL have parameter N_H, default 16, H-matrix element count.
REQ-003 SHALL have parameter N_Y, default 8, Y-vector element count (N_Y <= N_H).
REQ-004 SHALL have parameter RES_W, default 12, decoder result width in bits (1..32).
REQ-005 SHALL have parameter TIMEOUT_CYC, default 5000000, inter-byte receive timeout in clocks.
REQ-006 SHALL have port CLOCK_50  input  1  system clock; all logic on its rising edge.
REQ-007 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port rx_byte  input  8  received UART byte.
REQ-009 SHALL have port rx_valid  input  1  one-cycle strobe; rx_byte is valid in that cycle.
REQ-010 SHALL have port tx_byte  output  8  byte to transmit.
REQ-011 SHALL have port tx_start  output  1  one-cycle transmit request.
REQ-012 SHALL have port tx_busy  input  1  transmitter busy.
REQ-013 SHALL have ports h_re_out, h_im_out  output  DATA_W  streamed H element; h_valid  output  1  qualifier.
REQ-014 SHALL have ports y_re_out, y_im_out  output  DATA_W  streamed Y element; y_valid  output  1  qualifier.
REQ-015 SHALL have port start  output  1  one-cycle pulse marking the first stream cycle.
REQ-016 SHALL have port res_valid  input  1  asynchronous result strobe, held at least 3 clocks.
REQ-017 SHALL have port res_data  input  RES_W  decoder result, stable while res_valid is high.
REQ-018 SHALL have port frame_err  output  1  sticky frame error flag.
REQ-019 SHALL have port state_dbg  output  4  current FSM state encoding.

Function
REQ-020 Frame format SHALL be: header (0xAA = H, 0xBB = Y), then N*2*(DATA_W/8) payload bytes, then one checksum byte equal to the XOR of all payload bytes.
REQ-021 Each element SHALL carry re then im, each little-endian (LSB byte first).
REQ-022 FSM states SHALL be IDLE, RX_H, RX_Y, RX_CHK, ACK, STREAM, WAIT_RES, TX_RES, TX_WAIT.
REQ-023 In IDLE, rx_valid with 0xAA SHALL go to RX_H; 0xBB SHALL go to RX_Y; any other byte SHALL be ignored.
REQ-024 A valid header SHALL clear frame_err and the byte, element and checksum counters.
REQ-025 Each assembled element SHALL be written into the H or Y store at its element index.
REQ-026 After the last payload byte the FSM SHALL enter RX_CHK; the next byte is the checksum.
REQ-027 Checksum match SHALL set h_loaded or y_loaded and queue ACK byte 0x06.
REQ-028 Checksum mismatch SHALL clear the corresponding loaded flag, set frame_err and queue NAK 0x15.
REQ-029 Every tx byte SHALL wait for tx_busy low, then drive tx_byte with tx_start=1 for exactly one cycle, then idle one cycle before re-checking tx_busy.
REQ-030 After ACK/NAK the FSM SHALL go to STREAM if h_loaded and y_loaded are both set, else to IDLE; H/Y arrival order SHALL be free.
REQ-031 STREAM SHALL last N_H cycles; cycle k: h_valid=1 with H[k]; y_valid=1 with Y[k] for k<N_Y, else 0.
REQ-032 start SHALL be 1 only in STREAM cycle 0.
REQ-033 On STREAM exit both loaded flags SHALL clear and the FSM SHALL enter WAIT_RES.
REQ-034 res_valid and res_data SHALL pass through a 2-FF synchroniser.
REQ-035 A rising edge of synchronised res_valid SHALL latch res_data and enter TX_RES.
REQ-036 TX_RES SHALL send ceil(RES_W/8) bytes MSB byte first, zero-padded at the top, then return to IDLE.
REQ-037 In RX_H, RX_Y or RX_CHK, TIMEOUT_CYC clocks without rx_valid SHALL return the FSM to IDLE, set frame_err, clear that frame's loaded flag and send no byte.
REQ-038 rx_valid in ACK, STREAM, WAIT_RES, TX_RES or TX_WAIT SHALL be ignored.
REQ-039 Re-sending an already loaded matrix SHALL overwrite it; the result depends on that frame's checksum.

Reset
REQ-040 Reset SHALL force IDLE and clear all counters, loaded flags, synchronisers, tx_start, tx_byte, start, h_valid, y_valid, all data outputs and frame_err to 0, at any time including mid-stream or mid-transmit.
REQ-041 After reset release, a header byte SHALL be accepted on the first clock.

Verification (bench parameters: DATA_W=16, N_H=2, N_Y=1, RES_W=12, TIMEOUT_CYC=100)
REQ-042 AA 01 00 02 00 03 00 04 00 04 -> tx 0x06; no stream.
REQ-043 Then BB 05 00 06 00 03 -> tx 0x06; then stream cycle0: start=1, h=(1,2), y=(5,6), y_valid=1; cycle1: h=(3,4), y_valid=0.
REQ-044 res_data=0xABC with res_valid high for 3 clocks -> tx 0x0A then 0xBC; state_dbg returns to IDLE.
REQ-045 AA frame with checksum byte 0x05 -> tx 0x15, frame_err=1; a following Y frame does not trigger a stream.
REQ-046 AA 01 00, then 100 idle clocks -> IDLE, frame_err=1, no tx_start.
REQ-047 Reset asserted in STREAM cycle 1 -> all outputs 0 next edge; a new full H+Y exchange then behaves as in REQ-042 and REQ-043.
